seq_pattern_detector: RTL and testbench

//   Programmable serial bit-pattern detector; successor to the fixed-pattern detectors in the traffic-light block.

---
 rtl/seq_det_pkg.sv | 19 +
 rtl/seq_det_window.sv | 66 ++++++
 rtl/seq_pattern_detector.sv | 130 +++++++++++++
 tb/tb_seq_pattern_detector.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// ============================================================================
// seq_det_pkg : shared state encoding and sizing helper for seq_pattern_detector
// Revision   : 1.0
// ============================================================================
`default_nettype none

package seq_det_pkg;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_fill = 2'd1;
    localparam logic [1:0] c_st_hunt = 2'd2;

    function automatic int seq_len_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_det_window.sv
// ============================================================================
// seq_det_window : bit history, fill counter and length-masked comparator
// Revision       : 1.0
// ============================================================================
`default_nettype none

module seq_det_window #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             shift_i,
    input  logic             din_i,
    input  logic             no_overlap_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [PAT_W-1:0] pattern_i,
    output logic             hit_o,
    output logic             full_o
);

    logic [PAT_W-1:0] hist_q, hist_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0] w_window;
    logic [PAT_W-1:0] w_mask;
    logic [LEN_W-1:0] w_fill_next;

    assign w_window = {hist_q[PAT_W-2:0], din_i};

    generate
        for (genvar i = 0; i < PAT_W; i++) begin : g_mask
            assign w_mask[i] = (LEN_W'(i) < len_i);
        end
    endgenerate

    // fill saturates at len so stale history beyond the pattern never matters
    assign w_fill_next = (fill_q >= len_i) ? len_i : fill_q + LEN_W'(1);
    assign full_o      = shift_i && (w_fill_next >= len_i);
    assign hit_o       = full_o && (((w_window ^ pattern_i) & w_mask) == '0);

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clear_i) begin
            hist_d = '0;
            fill_d = '0;
        end else if (shift_i) begin
            hist_d = w_window;
            fill_d = (hit_o && no_overlap_i) ? '0 : w_fill_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_pattern_detector.sv
// ============================================================================
// seq_pattern_detector : run-time programmable serial pattern detector
// Revision             : 1.0
// ============================================================================
`default_nettype none

module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8,
    localparam int LEN_W = seq_len_w(PAT_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_load_i,
    input  logic [PAT_W-1:0] cfg_pattern_i,
    input  logic [LEN_W-1:0] cfg_len_i,
    input  logic             cfg_overlap_i,
    input  logic             din_valid_i,
    input  logic             din_i,
    input  logic             cnt_clear_i,
    output logic             match_o,
    output logic [CNT_W-1:0] match_cnt_o,
    output logic             cfg_err_o,
    output logic             armed_o
);

    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

    logic [1:0]       state_q,   state_d;
    logic [PAT_W-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0] len_q,     len_d;
    logic             overlap_q, overlap_d;
    logic             match_q,   match_d;
    logic             err_q,     err_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;

    logic w_len_ok;
    logic w_shift;
    logic w_hit;
    logic w_full;

    assign w_len_ok = (cfg_len_i != '0) && (cfg_len_i <= LEN_W'(PAT_W));
    // a bit arriving with cfg_load belongs to neither configuration
    assign w_shift  = din_valid_i && !cfg_load_i && (state_q != c_st_idle);

    seq_det_window #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_window (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (cfg_load_i),
        .shift_i      (w_shift),
        .din_i        (din_i),
        .no_overlap_i (!overlap_q),
        .len_i        (len_q),
        .pattern_i    (pattern_q),
        .hit_o        (w_hit),
        .full_o       (w_full)
    );

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        err_d     = 1'b0;
        match_d   = w_hit;
        cnt_d     = cnt_q;

        if (cfg_load_i) begin
            if (w_len_ok) begin
                pattern_d = cfg_pattern_i;
                len_d     = cfg_len_i;
                overlap_d = cfg_overlap_i;
                state_d   = c_st_fill;
            end else begin
                pattern_d = '0;
                len_d     = '0;
                overlap_d = 1'b0;
                err_d     = 1'b1;
                state_d   = c_st_idle;
            end
        end else if (w_shift) begin
            case (state_q)
                c_st_fill: begin
                    if (w_hit && !overlap_q) state_d = c_st_fill;
                    else if (w_full)         state_d = c_st_hunt;
                end
                c_st_hunt: begin
                    if (w_hit && !overlap_q) state_d = c_st_fill;
                end
                default: state_d = c_st_idle;
            endcase
        end

        if (cnt_clear_i)                  cnt_d = '0;
        else if (w_hit && cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= c_st_idle;
            pattern_q <= '0;
            len_q     <= '0;
            overlap_q <= 1'b0;
            match_q   <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            match_q   <= match_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign match_o     = match_q;
    assign match_cnt_o = cnt_q;
    assign cfg_err_o   = err_q;
    assign armed_o     = (state_q != c_st_idle);

endmodule

`default_nettype wire

// File: tb/tb_seq_pattern_detector.sv
// ============================================================================
// tb_seq_pattern_detector : directed and random checks against a queue model
// Revision                : 1.0
// ============================================================================
`default_nettype none

module tb_seq_pattern_detector;

    localparam int PAT_W = 8;
    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             cfg_load = 1'b0;
    logic [PAT_W-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             cfg_overlap = 1'b0;
    logic             din_valid = 1'b0;
    logic             din = 1'b0;
    logic             cnt_clear = 1'b0;

    logic       match8, err8, armed8;
    logic [7:0] cnt8;
    logic       match2, err2, armed2;
    logic [1:0] cnt2;

    seq_pattern_detector #(.PAT_W(PAT_W), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_load_i(cfg_load), .cfg_pattern_i(cfg_pattern),
        .cfg_len_i(cfg_len), .cfg_overlap_i(cfg_overlap), .din_valid_i(din_valid),
        .din_i(din), .cnt_clear_i(cnt_clear), .match_o(match8), .match_cnt_o(cnt8),
        .cfg_err_o(err8), .armed_o(armed8)
    );

    seq_pattern_detector #(.PAT_W(PAT_W), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .cfg_load_i(cfg_load), .cfg_pattern_i(cfg_pattern),
        .cfg_len_i(cfg_len), .cfg_overlap_i(cfg_overlap), .din_valid_i(din_valid),
        .din_i(din), .cnt_clear_i(cnt_clear), .match_o(match2), .match_cnt_o(cnt2),
        .cfg_err_o(err2), .armed_o(armed2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the accepted bits since the last load/flush, newest at the back
    bit         e_match, e_err, e_armed, m_ov, m_hit;
    int         e_cnt8, e_cnt2, m_len;
    logic [7:0] m_pat;
    bit         q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_match = 0; e_err = 0; e_armed = 0; e_cnt8 = 0; e_cnt2 = 0;
            m_len = 0; m_pat = '0; m_ov = 0; q.delete();
        end else begin
            e_match = 0;
            e_err   = 0;
            if (cfg_load) begin
                q.delete();
                if (cfg_len >= 1 && cfg_len <= PAT_W) begin
                    m_len = int'(cfg_len); m_pat = cfg_pattern; m_ov = cfg_overlap; e_armed = 1;
                end else begin
                    m_len = 0; e_armed = 0; e_err = 1;
                end
            end else if (din_valid && e_armed) begin
                q.push_back(din);
                if (q.size() > PAT_W) void'(q.pop_front());
                m_hit = (q.size() >= m_len);
                for (int k = 0; k < m_len; k++)
                    if (m_hit && q[q.size()-1-k] != m_pat[k]) m_hit = 0;
                if (m_hit) begin
                    e_match = 1;
                    if (!m_ov) q.delete();
                end
            end
            if (cnt_clear) begin
                e_cnt8 = 0; e_cnt2 = 0;
            end else if (e_match) begin
                if (e_cnt8 < 255) e_cnt8++;
                if (e_cnt2 < 3)   e_cnt2++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("match",  match8, e_match);
            check("cnt8",   cnt8,   e_cnt8);
            check("cnt2",   cnt2,   e_cnt2);
            check("cfg_err", err8,  e_err);
            check("armed",  armed8, e_armed);
            check("match2", match2, e_match);
            check("armed2", armed2, e_armed);
            check("cfg_err2", err2, e_err);
        end
    end

    task automatic step(input bit v, input bit d);
        din_valid = v; din = d;
        @(posedge clk); #1;
        din_valid = 1'b0; din = 1'b0;
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input bit ov);
        cfg_load = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = ov;
        @(posedge clk); #1;
        cfg_load = 1'b0;
    endtask

    task automatic feed(input logic [15:0] bits, input int n, output int hits);
        hits = 0;
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b1, bits[i]);
            if (match8) hits++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int h;
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;

        // reset holds outputs low whatever the inputs do
        for (int i = 0; i < 5; i++) begin
            cfg_load = 1'($urandom); cfg_len = 4'($urandom); cfg_pattern = 8'($urandom);
            din_valid = 1'($urandom); din = 1'($urandom); cnt_clear = 1'($urandom);
            @(posedge clk); #1;
            check("rst_match", match8, 0);
            check("rst_cnt", cnt8, 0);
            check("rst_armed", armed8, 0);
            check("rst_err", err8, 0);
        end
        cfg_load = 0; cfg_len = 0; cfg_pattern = 0; din_valid = 0; din = 0; cnt_clear = 0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // basic match
        load(8'b1011, 4'd4, 1'b0);
        check("t2_armed", armed8, 1);
        step(1, 1); check("t2_bit1", match8, 0);
        step(1, 0); step(1, 1); check("t2_bit3", match8, 0);
        step(1, 1); check("t2_match", match8, 1); check("t2_cnt", cnt8, 1);
        step(0, 0); check("t2_pulse", match8, 0);

        // overlap versus flush
        load(8'b101, 4'd3, 1'b1);
        feed(16'b10101, 5, h); check("t3_ov_hits", h, 2);
        load(8'b101, 4'd3, 1'b0);
        feed(16'b10101, 5, h); check("t3_noov_hits", h, 1);

        // gaps inside the pattern
        load(8'b1011, 4'd4, 1'b0);
        step(1, 1); step(0, 0); step(1, 0); step(0, 1); step(0, 1); step(1, 1);
        check("t4_gap_early", match8, 0);
        step(1, 1); check("t4_gap_match", match8, 1);

        // illegal lengths
        load(8'h0F, 4'd0, 1'b0);
        check("t4_len0_err", err8, 1); check("t4_len0_armed", armed8, 0);
        step(1, 1); check("t4_err_pulse", err8, 0); check("t4_idle_nomatch", match8, 0);
        load(8'hFF, 4'd9, 1'b0);
        check("t4_len9_err", err8, 1); check("t4_len9_armed", armed8, 0);

        // saturation and clear-with-match
        cnt_clear = 1'b1;
        load(8'h01, 4'd1, 1'b1);
        cnt_clear = 1'b0;
        feed(16'b11111, 5, h);
        check("t5_hits", h, 5); check("t5_cnt8", cnt8, 5); check("t5_cnt2_sat", cnt2, 3);
        cnt_clear = 1'b1;
        step(1, 1);
        cnt_clear = 1'b0;
        check("t5_clr_match", match8, 1); check("t5_clr_cnt8", cnt8, 0); check("t5_clr_cnt2", cnt2, 0);

        // reload mid-pattern drops the old pattern
        load(8'b1011, 4'd4, 1'b0);
        step(1, 1); step(1, 0); step(1, 1);
        load(8'b0110, 4'd4, 1'b0);
        step(1, 1); check("t6_reload_nomatch", match8, 0);

        // asynchronous reset mid-FILL
        load(8'h01, 4'd1, 1'b1);
        step(1, 1);
        load(8'b1011, 4'd4, 1'b0);
        step(1, 1);
        check("t6_pre_cnt", cnt8, 1); check("t6_pre_armed", armed8, 1);
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_cnt", cnt8, 0); check("t6_rst_armed", armed8, 0); check("t6_rst_match", match8, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        feed(16'b1011, 4, h);
        check("t6_post_hits", h, 0); check("t6_post_armed", armed8, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cfg_load    = ($urandom_range(0, 19) == 0);
            cfg_len     = 4'($urandom_range(0, 9));
            cfg_pattern = 8'($urandom);
            cfg_overlap = 1'($urandom);
            din_valid   = ($urandom_range(0, 9) < 7);
            din         = 1'($urandom);
            cnt_clear   = ($urandom_range(0, 49) == 0);
            @(posedge clk); #1;
            if ($urandom_range(0, 499) == 0) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end
        cfg_load = 0; din_valid = 0; cnt_clear = 0;
        @(posedge clk); #1;
        chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
